// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, port owner,
// default access latency and the latched request record.
package mem_arbiter_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int LAT_DEFAULT = 2;
   localparam int CNT_W       = 4;

   typedef struct packed {
      logic        owner;
      logic        wr;
      logic        err;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
module mem_lat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sequencing a single-ported memory between fetch and data ports.
// Optional fetch starvation guard is enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LAT        = LAT_DEFAULT,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_done,
   output logic [15:0] i_rdata,
   output logic        i_stall,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        d_err,
   output logic        d_stall,
   output logic        m_en,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   output logic [1:0]  dbg_state_o
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

   logic [1:0]       state_q, state_d;
   req_t             req_q, req_d;
   logic [15:0]      i_rdata_q, i_rdata_d;
   logic [15:0]      d_rdata_q, d_rdata_d;
   logic             take_d, take_i, force_i;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt;

   assign take_d = (state_q == IDLE) && d_req && !force_i;
   assign take_i = (state_q == IDLE) && i_req && !take_d;

   mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (take_d | take_i),
      .load_val_i (LAT_M1),
      .dec_i      (state_q == ACCESS),
      .cnt_o      (cnt),
      .zero_o     (cnt_zero)
   );

`ifdef MEMARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      if (take_i) begin
         starve_d = 3'd0;
      end else if (take_d && i_req && (starve_q != 3'd7)) begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 3'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign force_i = (starve_q >= 3'(STARVE_MAX)) && i_req && d_req;
`else
   // Strict data priority: STARVE_MAX is legal only >= 1, so this is never set.
   assign force_i = (STARVE_MAX < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      case (state_q)
         IDLE: begin
            if (take_d) begin
               req_d   = '{owner: OWN_D, wr: d_wr, err: d_addr[0], addr: d_addr, wdata: d_wdata};
               state_d = d_addr[0] ? RESP : ACCESS;
            end else if (take_i) begin
               req_d   = '{owner: OWN_I, wr: 1'b0, err: 1'b0, addr: i_addr, wdata: 16'h0000};
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read data lands in the owner's register on the last access cycle; a
   // misaligned data access completes with zero load data.
   always_comb begin
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      if ((state_q == ACCESS) && cnt_zero && !req_q.wr) begin
         if (req_q.owner == OWN_I) begin
            i_rdata_d = m_rdata;
         end else begin
            d_rdata_d = m_rdata;
         end
      end
      if (take_d && d_addr[0]) begin
         d_rdata_d = 16'h0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q     <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         req_q     <= req_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      m_en    = 1'b0;
      m_wr    = 1'b0;
      m_addr  = 16'h0000;
      m_wdata = 16'h0000;
      i_done  = 1'b0;
      d_done  = 1'b0;
      d_err   = 1'b0;
      case (state_q)
         ACCESS: begin
            m_en    = 1'b1;
            m_wr    = req_q.wr && (cnt == LAT_M1);
            m_addr  = req_q.addr;
            m_wdata = req_q.wdata;
         end
         RESP: begin
            i_done = (req_q.owner == OWN_I);
            d_done = (req_q.owner == OWN_D);
            d_err  = (req_q.owner == OWN_D) && req_q.err;
         end
         default: ;
      endcase
   end

   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_stall     = i_req && !i_done && !rst;
   assign d_stall     = d_req && !d_done && !rst;
   assign dbg_state_o = state_q;

endmodule
